// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: operation selects,
// multiply/divide FSM states and default datapath widths.
package mips_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic MULTORDIV_MULT = 1'b0;
  localparam logic MULTORDIV_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;
endpackage

// File: rtl/div_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per enabled step.
// The quotient register doubles as the dividend shift register.
module div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, dvs};
  // When the divisor fits, the difference is below dvs and fits in WIDTH bits.
  assign diff    = shifted[WIDTH-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (reset) begin
      dvs <= '0;
      quo <= '0;
      rem <= '0;
    end else if (load) begin
      dvs <= divisor;
      quo <= dividend;
      rem <= '0;
    end else if (step) begin
      if (fits) begin
        rem <= diff;
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed MULT (radix-2 Booth) / DIV (restoring on magnitudes) unit
// feeding HI/LO; done pulses once per accepted operation.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             MultOrDiv,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             ErroDiv,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             op_div, err, neg_q, neg_r;
  logic [WIDTH-1:0] mcand, b_lo;
  logic [WIDTH:0]   b_hi;
  logic             b_q;
  logic [WIDTH:0]   m_ext, booth_sum;
  logic [WIDTH-1:0] a_mag, b_mag, quo_mag, rem_mag;
  logic             last, b_zero, div_load;

  assign last     = (cnt == '1);
  assign b_zero   = (B == '0);
  assign a_mag    = A[WIDTH-1] ? -A : A;
  assign b_mag    = B[WIDTH-1] ? -B : B;
  assign div_load = (state == ST_IDLE) && start && (MultOrDiv == MULTORDIV_DIV) && !b_zero;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk      (clk),
    .reset    (reset),
    .load     (div_load),
    .step     (state == ST_DIV),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo      (quo_mag),
    .rem      (rem_mag)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (MultOrDiv == MULTORDIV_MULT) state_nxt = ST_MULT;
          else if (b_zero)                 state_nxt = ST_FINISH;
          else                             state_nxt = ST_DIV;
        end
      end
      ST_MULT, ST_DIV: begin
        busy = 1'b1;
        if (last) state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        busy      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Booth hi carries one guard bit so subtracting -2^(W-1) cannot overflow.
  always_comb begin
    m_ext = {mcand[WIDTH-1], mcand};
    case ({b_lo[0], b_q})
      2'b01:   booth_sum = b_hi + m_ext;
      2'b10:   booth_sum = b_hi - m_ext;
      default: booth_sum = b_hi;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      op_div  <= 1'b0;
      err     <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      mcand   <= '0;
      b_hi    <= '0;
      b_lo    <= '0;
      b_q     <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      done    <= 1'b0;
      ErroDiv <= 1'b0;
    end else begin
      done    <= 1'b0;
      ErroDiv <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt    <= '0;
            op_div <= MultOrDiv;
            err    <= (MultOrDiv == MULTORDIV_DIV) && b_zero;
            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r  <= A[WIDTH-1];
            mcand  <= A;
            b_hi   <= '0;
            b_lo   <= B;
            b_q    <= 1'b0;
          end
        end
        ST_MULT: begin
          cnt  <= cnt + 1'b1;
          b_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          b_lo <= {booth_sum[0], b_lo[WIDTH-1:1]};
          b_q  <= b_lo[0];
        end
        ST_DIV: cnt <= cnt + 1'b1;
        ST_FINISH: begin
          done    <= 1'b1;
          ErroDiv <= err;
          if (!err) begin
            if (op_div) begin
              LO <= neg_q ? -quo_mag : quo_mag;
              HI <= neg_r ? -rem_mag : rem_mag;
            end else begin
              HI <= b_hi[WIDTH-1:0];
              LO <= b_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO/error/latency queued at
// issue time from a 64-bit arithmetic model, compared when done pulses.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset, start, MultOrDiv;
  logic [31:0] A, B;
  logic        busy, done, ErroDiv;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0, bad = 0, done_cnt = 0;
  logic [31:0] model_hi = '0, model_lo = '0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .MultOrDiv(MultOrDiv),
    .A(A), .B(B), .busy(busy), .done(done), .ErroDiv(ErroDiv), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sbv, p, q, r;
    sa  = $signed(a);
    sbv = $signed(b);
    if (op == 1'b0) begin
      p = sa * sbv;
      e.hi = p[63:32]; e.lo = p[31:0]; e.err = 1'b0; e.lat = 33;
    end else if (b == 32'd0) begin
      e.hi = model_hi; e.lo = model_lo; e.err = 1'b1; e.lat = 1;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.hi = r[31:0]; e.lo = q[31:0]; e.err = 1'b0; e.lat = 33;
    end
    sb.push_back(e);
    MultOrDiv = op; A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b want=1", busy); end
  endtask

  task automatic collect(input string name, input int n0);
    exp_t e;
    int   n;
    bit   seen;
    n = n0; seen = 1'b0;
    while (n < 80 && !seen) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen || sb.size() == 0) begin
      bad++;
      $display("FAIL %s no_done_or_empty_sb seen=%0d sb=%0d", name, seen, sb.size());
      if (sb.size() > 0) sb.delete(0);
      return;
    end
    e = sb.pop_front();
    total += 5;
    if (n != e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, e.lat); end
    if (HI !== e.hi) begin bad++; $display("FAIL %s HI got=%h want=%h", name, HI, e.hi); end
    if (LO !== e.lo) begin bad++; $display("FAIL %s LO got=%h want=%h", name, LO, e.lo); end
    if (ErroDiv !== e.err) begin bad++; $display("FAIL %s ErroDiv got=%b want=%b", name, ErroDiv, e.err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b want=0", name, busy); end
    if (!e.err) begin model_hi = e.hi; model_lo = e.lo; end
    tick();
    total++;
    if (done !== 1'b0 || ErroDiv !== 1'b0) begin
      bad++; $display("FAIL %s pulse_width done=%b err=%b want=0", name, done, ErroDiv);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; MultOrDiv = 1'b0; A = 32'd3; B = 32'd4;
    tick(); tick();
    reset = 1'b0; start = 1'b0;
    tick();
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset done got=%b want=0", done); end
    if (ErroDiv !== 1'b0) begin bad++; $display("FAIL reset ErroDiv got=%b want=0", ErroDiv); end
    if (HI !== 32'd0) begin bad++; $display("FAIL reset HI got=%h want=0", HI); end
    if (LO !== 32'd0) begin bad++; $display("FAIL reset LO got=%h want=0", LO); end
  endtask

  task automatic test_mult();
    issue(1'b0, 32'd7, 32'hFFFFFFFD);          collect("mult_7_m3", 0);
    issue(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF);   collect("mult_maxpos", 0);
    issue(1'b0, 32'h80000000, 32'h80000000);   collect("mult_minneg", 0);
    issue(1'b0, 32'd0, 32'hDEADBEEF);          collect("mult_zero", 0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, $urandom, $urandom);         collect("mult_rand", 0);
    end
  endtask

  task automatic test_div();
    issue(1'b1, 32'hFFFFFFF9, 32'd2);          collect("div_m7_2", 0);
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF);   collect("div_overflow", 0);
    issue(1'b1, 32'd100, 32'hFFFFFFF9);        collect("div_100_m7", 0);
    issue(1'b1, 32'd3, 32'd10);                collect("div_small", 0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, $urandom, $urandom_range(1, 32'h7FFFFFFF)); collect("div_rand", 0);
    end
  endtask

  task automatic test_div_zero();
    issue(1'b1, 32'd5, 32'd0);
    collect("div_by_zero", 0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL div_zero busy_after got=%b want=0", busy); end
  endtask

  task automatic test_start_ignored();
    int d0;
    d0 = done_cnt;
    issue(1'b0, 32'h12345678, 32'hFEDCBA98);
    repeat (9) tick();
    MultOrDiv = 1'b1; A = 32'd9; B = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    collect("start_ignored", 10);
    repeat (40) tick();
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL start_ignored done_count got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    issue(1'b1, 32'd100, 32'd7);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    model_hi = '0; model_lo = '0;
    total += 4;
    if (HI !== 32'd0) begin bad++; $display("FAIL reset_mid HI got=%h want=0", HI); end
    if (LO !== 32'd0) begin bad++; $display("FAIL reset_mid LO got=%h want=0", LO); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_mid done got=%b want=0", done); end
    tick();
    total++;
    if (done_cnt != d0) begin bad++; $display("FAIL reset_mid stray_done got=%0d want=%0d", done_cnt, d0); end
    issue(1'b1, 32'hFFFFFF9C, 32'd7);
    collect("after_reset_div", 0);
  endtask

  task automatic test_back_to_back();
    issue(1'b1, 32'd1000, 32'd33);             collect("b2b_div", 0);
    issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);   collect("b2b_mult", 0);
    issue(1'b1, 32'd42, 32'd0);                collect("b2b_divzero", 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MultOrDiv = 1'b0; A = '0; B = '0;
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
